// File: rtl/divider_scheduler.sv
// divider_scheduler: round-robin arbiter that shares one external
// sequential divider among N_REQ requesters. Degenerate operands
// (zero divisor or dividend >= divisor) are answered locally with a
// saturated quotient and never reach the divider.
module divider_scheduler #(
    parameter int N_REQ       = 4,
    parameter int DIV_LATENCY = 11
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*16-1:0]        req_dividend,
    input  logic [N_REQ*16-1:0]        req_divider,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [7:0]                 rsp_quotient,
    output logic                       rsp_sat,
    output logic                       busy,
    output logic                       div_en,
    output logic [15:0]                div_dividend,
    output logic [15:0]                div_divider,
    input  logic [7:0]                 div_quotient
);

    localparam int          IDW = $clog2(N_REQ);
    localparam int          CW  = $clog2(DIV_LATENCY + 1);
    localparam int unsigned NR  = N_REQ;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   grant_id;
    logic             grant_found;
    logic [15:0]      sel_a, sel_b;
    logic             degenerate;
    logic             accept;
    logic             capture;
    logic [15:0]      lat_a, lat_b;
    logic [IDW-1:0]   lat_id;
    logic [CW-1:0]    cnt_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [7:0]       rsp_quot_q;
    logic             rsp_sat_q;
    int unsigned      idx;

    // Round-robin search: first pending requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        sel_a       = '0;
        sel_b       = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            idx = (32'(rr_ptr_q) + i) % NR;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
                sel_a       = req_dividend[idx*16 +: 16];
                sel_b       = req_divider[idx*16 +: 16];
            end
        end
    end

    assign degenerate = (sel_b == 16'd0) || (sel_a >= sel_b);

    // Next-state and control outputs for the scheduling FSM.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        div_en    = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (grant_found) begin
                    req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
                    accept    = 1'b1;
                    state_d   = degenerate ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_en  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nRst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Operand latches, pointer, wait counter and response registers.
    // Response registers load only on entry to RESP so they hold their
    // previous values for the whole job and afterwards.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            rr_ptr_q   <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_id     <= '0;
            cnt_q      <= '0;
            rsp_id_q   <= '0;
            rsp_quot_q <= '0;
            rsp_sat_q  <= 1'b0;
        end else begin
            if (accept) begin
                lat_a    <= sel_a;
                lat_b    <= sel_b;
                lat_id   <= grant_id;
                rr_ptr_q <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                if (degenerate) begin
                    rsp_id_q   <= grant_id;
                    rsp_quot_q <= 8'hFF;
                    rsp_sat_q  <= 1'b1;
                end
            end
            if (state_q == ISSUE)
                cnt_q <= CW'(DIV_LATENCY - 1);
            else if (state_q == WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (capture) begin
                rsp_id_q   <= lat_id;
                rsp_quot_q <= div_quotient;
                rsp_sat_q  <= 1'b0;
            end
        end
    end

    assign rsp_id       = rsp_id_q;
    assign rsp_quotient = rsp_quot_q;
    assign rsp_sat      = rsp_sat_q;
    assign div_dividend = lat_a;
    assign div_divider  = lat_b;

endmodule

// File: doc/divider_scheduler.md
# divider_scheduler

Shares one `sequential_divider` instance among `N_REQ` requesters, such as synth voices needing fractional ratios. Arbitration is round-robin. The block latches the winning operands, pulses the divider's `en`, and waits the divider's fixed latency. It then returns the 8-bit quotient on a shared response bus, tagged with the requester ID. Degenerate operands (zero divisor, or dividend ≥ divisor) are resolved locally with a saturated result and never reach the divider.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `DIV_LATENCY`, 11: cycles from a `div_en` pulse to a valid `div_quotient`.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `nRst`, input, 1: one clock; reset is synchronous and active-low.
- `req_valid`, input, `N_REQ`: request pending, one bit per requester.
- `req_dividend`, input, `N_REQ*16`: requester i occupies bits [16i+15:16i].
- `req_divider`, input, `N_REQ*16`: same packing as `req_dividend`.
- `req_ready`, output, `N_REQ`: one-hot grant. Acceptance is `req_valid[i] & req_ready[i]`.
- `rsp_valid`, output, 1: one-cycle result strobe.
- `rsp_id`, output, `$clog2(N_REQ)`: index of the requester that owns the result.
- `rsp_quotient`, output, 8: `floor(dividend*256/divider)`, or `8'hFF` when saturated.
- `rsp_sat`, output, 1: result saturated locally.
- `busy`, output, 1: high in every state except IDLE.
- `div_en`, output, 1: divider start pulse.
- `div_dividend`, output, 16: operand to the divider.
- `div_divider`, output, 16: operand to the divider.
- `div_quotient`, input, 8: result from the divider.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` bit is set, grant the first set bit searching upward from `rr_ptr` with wrap-around.
  - `req_ready[g]=1` combinationally in that same cycle.
  - Latch dividend, divider and `g`.
  - Set `rr_ptr <= (g+1) mod N_REQ`.
  - If divider==0 or dividend≥divider: set the saturation flag, set the held quotient to `8'hFF`, go to RESP.
  - Otherwise go to ISSUE.
  - With no request pending, stay in IDLE; `req_ready` is all zero.
- **ISSUE**
  - `div_en=1` for exactly this cycle.
  - Load the wait counter with `DIV_LATENCY-1`.
  - Go to WAIT.
- **WAIT**
  - Decrement the wait counter each cycle.
  - When the counter reads 0, capture `div_quotient` and go to RESP.
- **RESP**
  - `rsp_valid=1` for one cycle, with `rsp_id`, `rsp_quotient` and `rsp_sat` driven from registers.
  - Go to IDLE.
- `div_dividend` and `div_divider` come from the latched registers. They stay stable from ISSUE through WAIT, because the divider samples them one cycle after `en`.
- `req_ready` is zero outside IDLE. New requests are never accepted while a job is in flight.
- A requester holds `req_valid` and its operands until accepted. Dropping `req_valid` before acceptance withdraws the request; this is legal.
- Requester IDs outside `0..N_REQ-1` never occur.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_quotient=0`, `rsp_sat=0`, `busy=0`, `div_en=0`, `div_dividend=0`, `div_divider=0`, `rr_ptr=0`, state IDLE.
- Take acceptance in cycle A.
  - Normal job: ISSUE at A+1; capture at A+1+`DIV_LATENCY`; `rsp_valid` at A+`DIV_LATENCY`+2. With the default latency, `rsp_valid` is at A+13.
  - Saturated job: `rsp_valid` at A+1. No `div_en` is issued.
- IDLE follows RESP. Back-to-back acceptance is therefore possible at `rsp_valid`+1. Peak throughput is one normal job per `DIV_LATENCY`+3 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. A persistently requesting index waits at most N_REQ−1 jobs.
- `nRst` low in any state, mid-job included:
  - Everything returns to reset values in the next cycle.
  - The in-flight result is discarded; no `rsp_valid` is produced.
  - The divider must share the same reset net.
- Response outputs hold their last values after `rsp_valid` falls.

## Test plan
- Reset, then req0 with dividend=1, divider=4 → `div_en` at A+1; `rsp_valid` at A+13 with id=0, quotient `8'h40`, sat=0.
- req2 with dividend=100, divider=300 → quotient `8'h55`. Then dividend=3, divider=4 → quotient `8'hC0`.
- req1 with divider=0, and req3 with dividend=500, divider=500 → each gets `rsp_valid` at A+1 with quotient `8'hFF`, sat=1, and `div_en` never asserted.
- All four requesters held valid with `rr_ptr`=0 → grant order 0,1,2,3,0, one `rsp_valid` per job, no index repeated before all are served.
- Reset asserted during WAIT → next cycle is IDLE with all outputs at reset values, no `rsp_valid`; a fresh req0 with 1/2 → quotient `8'h80`.
- `req_valid` raised while `busy` → `req_ready` stays 0 until IDLE. Operands changed while unaccepted → the values present at acceptance are used.
